// File: rtl/instruction_memory_loadable_if.sv
// Load/fetch bus of the loadable instruction memory.
// The force_parity_flip debug signal exists only when IMEM_PARITY_EN is defined.
interface instruction_memory_loadable_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  load_start;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;
    logic                  load_done;
    logic                  ready;
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_stall;
    logic [DATA_WIDTH-1:0] instr;
    logic                  instr_valid;
    logic                  addr_fault;
    logic                  parity_err;
`ifdef IMEM_PARITY_EN
    logic                  force_parity_flip;
`endif

    modport master (
        output load_start, load_valid, load_data, load_last,
        output fetch_req, fetch_addr, fetch_stall,
`ifdef IMEM_PARITY_EN
        output force_parity_flip,
`endif
        input  load_ready, load_done, ready, instr, instr_valid, addr_fault, parity_err
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last,
        input  fetch_req, fetch_addr, fetch_stall,
`ifdef IMEM_PARITY_EN
        input  force_parity_flip,
`endif
        output load_ready, load_done, ready, instr, instr_valid, addr_fault, parity_err
    );
endinterface

// File: rtl/instruction_memory_loadable.sv
// Loadable instruction memory: words streamed in after reset, then served with 1-cycle latency.
// Optional per-word even parity when IMEM_PARITY_EN is defined.
module instruction_memory_loadable #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          DEPTH      = 64,
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD  = '0
) (
    input logic                          clk,
    input logic                          rst_n,
    instruction_memory_loadable_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e                state_q;
    logic [IDX_W-1:0]      ptr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  load_ready_q;
    logic                  load_done_q;
    logic                  ready_q;
    logic                  instr_valid_q;
    logic                  addr_fault_q;
    logic [DATA_WIDTH-1:0] instr_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_en;
    logic                  wr_last;
    logic                  fetch_fault;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [IDX_W-1:0]      rd_idx;

    // Full word address is compared against the count so high address bits never wrap.
    always_comb begin
        wr_en       = (state_q == StLoad) && !bus.load_start && bus.load_valid;
        wr_last     = bus.load_last || (ptr_q == IDX_W'(DEPTH - 1));
        word_addr   = bus.fetch_addr >> 2;
        rd_idx      = word_addr[IDX_W-1:0];
        fetch_fault = (bus.fetch_addr[1:0] != 2'b00) || (word_addr >= ADDR_WIDTH'(cnt_q));
    end

    // Array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr_q] <= bus.load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            cnt_q         <= '0;
            load_ready_q  <= 1'b0;
            load_done_q   <= 1'b0;
            ready_q       <= 1'b0;
            instr_valid_q <= 1'b0;
            addr_fault_q  <= 1'b0;
            instr_q       <= NOP_WORD;
        end else begin
            load_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.load_start) begin
                        state_q      <= StLoad;
                        ptr_q        <= '0;
                        cnt_q        <= '0;
                        load_ready_q <= 1'b1;
                    end
                end
                StLoad: begin
                    if (bus.load_start) begin
                        ptr_q <= '0;
                        cnt_q <= '0;
                    end else if (bus.load_valid) begin
                        ptr_q <= ptr_q + 1'b1;
                        cnt_q <= cnt_q + 1'b1;
                        if (wr_last) begin
                            state_q      <= StRun;
                            load_ready_q <= 1'b0;
                            load_done_q  <= 1'b1;
                            ready_q      <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    // A reload request takes priority over any fetch in the same cycle.
                    if (bus.load_start) begin
                        state_q       <= StLoad;
                        ptr_q         <= '0;
                        cnt_q         <= '0;
                        load_ready_q  <= 1'b1;
                        ready_q       <= 1'b0;
                        instr_valid_q <= 1'b0;
                        addr_fault_q  <= 1'b0;
                    end else if (!bus.fetch_stall) begin
                        if (bus.fetch_req) begin
                            instr_valid_q <= 1'b1;
                            addr_fault_q  <= fetch_fault;
                            instr_q       <= fetch_fault ? NOP_WORD : mem[rd_idx];
                        end else begin
                            instr_valid_q <= 1'b0;
                            addr_fault_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef IMEM_PARITY_EN
    logic mem_par [DEPTH];
    logic parity_err_q;
    logic rd_par_bad;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_par[ptr_q] <= (^bus.load_data) ^ bus.force_parity_flip;
        end
    end

    assign rd_par_bad = (^mem[rd_idx]) != mem_par[rd_idx];

    // Tracks instr_valid: cleared outside RUN, held under stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else if ((state_q != StRun) || bus.load_start) begin
            parity_err_q <= 1'b0;
        end else if (!bus.fetch_stall) begin
            parity_err_q <= bus.fetch_req && !fetch_fault && rd_par_bad;
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.load_ready  = load_ready_q;
    assign bus.load_done   = load_done_q;
    assign bus.ready       = ready_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.addr_fault  = addr_fault_q;

endmodule
